// File: rtl/utmi_pkg.sv
// rtl/utmi_pkg.sv - shared types and grant encodings for the UTMI transmit arbiter
package utmi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } utmi_tx_arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/utmi_tx_arb.sv
// rtl/utmi_tx_arb.sv - two-source packet arbiter and byte sequencer for the UTMI transmit pins
module utmi_tx_arb
  import utmi_pkg::*;
#(
  parameter int GAP_CYCLES = 8
) (
  input  logic       phy_clk_i,
  input  logic       rst_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  input  logic       RxActive_i,
  input  logic       TxReady_i,
  output logic [7:0] DataOut_o,
  output logic       TxValid_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       tx_underrun_o
);

  // A zero gap still needs a legal one-bit counter.
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  utmi_tx_arb_state_t state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               txvalid_q, txvalid_d;
  logic               last_q, last_d;
  logic               underrun_q, underrun_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               can_take;
  logic               take;
  logic               phy_done;

  // Granted requester's byte stream; the other requester is never looked at.
  assign sel_valid = ((grant_q == GRANT_REQ0) && req0_valid_i) ||
                     ((grant_q == GRANT_REQ1) && req1_valid_i);
  assign sel_data  = (grant_q == GRANT_REQ1) ? req1_data_i : req0_data_i;
  assign sel_last  = (grant_q == GRANT_REQ1) ? req1_last_i : req0_last_i;

  // The output slot can take a byte when it is empty or being drained this cycle,
  // and never once the final byte of the packet is already loaded.
  assign can_take = (state_q == SEND) && !last_q && (!txvalid_q || TxReady_i);
  assign take     = can_take && sel_valid;
  assign phy_done = txvalid_q && TxReady_i;

  assign req0_ready_o  = can_take && (grant_q == GRANT_REQ0);
  assign req1_ready_o  = can_take && (grant_q == GRANT_REQ1);
  assign DataOut_o     = data_q;
  assign TxValid_o     = txvalid_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != IDLE);
  assign tx_underrun_o = underrun_q;

  // Next-state and datapath decisions for grant, byte hand-off and gap timing.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    data_d     = data_q;
    txvalid_d  = txvalid_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!RxActive_i) begin
          if (req0_valid_i) begin
            grant_d = GRANT_REQ0;
            state_d = SEND;
          end else if (req1_valid_i) begin
            grant_d = GRANT_REQ1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (take) begin
          data_d    = sel_data;
          last_d    = sel_last;
          txvalid_d = 1'b1;
        end else if (phy_done) begin
          // Either the packet finished or the requester ran dry mid-packet;
          // both end the packet, only the latter is flagged.
          txvalid_d  = 1'b0;
          last_d     = 1'b0;
          grant_d    = GRANT_NONE;
          underrun_d = !last_q;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  // State registers; reset clears everything so a cut packet leaves no residue.
  always_ff @(posedge phy_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_NONE;
      data_q     <= 8'h00;
      txvalid_q  <= 1'b0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      txvalid_q  <= txvalid_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
